regfile_read_mux32: RTL and testbench

- 32-to-1 word multiplexer on the register-file read path.
- Selects one of 32 WIDTH-bit inputs, in00..in31, using a 5-bit select.
- Presents the chosen word on a registered output.
- Sits between the register array and the datapath read port; one mux instance per read port.

---
 rtl/regfile_read_mux32.sv | 136 +++++++++++++
 tb/tb_regfile_read_mux32.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/regfile_read_mux32.sv
`default_nettype none
// ============================================================================
// Module   : regfile_read_mux32
// Purpose  : Register-file read-port mux. Selects one of 32 WIDTH-bit words
//            with a 5-bit index and presents it on a registered output with
//            a load enable. One instance per read port.
// Options  : REGFILE_READ_MUX32_PARITY_EN adds out_par, a registered
//            even-parity bit of the selected word.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_read_mux32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in00,
  input  logic [WIDTH-1:0] in01,
  input  logic [WIDTH-1:0] in02,
  input  logic [WIDTH-1:0] in03,
  input  logic [WIDTH-1:0] in04,
  input  logic [WIDTH-1:0] in05,
  input  logic [WIDTH-1:0] in06,
  input  logic [WIDTH-1:0] in07,
  input  logic [WIDTH-1:0] in08,
  input  logic [WIDTH-1:0] in09,
  input  logic [WIDTH-1:0] in10,
  input  logic [WIDTH-1:0] in11,
  input  logic [WIDTH-1:0] in12,
  input  logic [WIDTH-1:0] in13,
  input  logic [WIDTH-1:0] in14,
  input  logic [WIDTH-1:0] in15,
  input  logic [WIDTH-1:0] in16,
  input  logic [WIDTH-1:0] in17,
  input  logic [WIDTH-1:0] in18,
  input  logic [WIDTH-1:0] in19,
  input  logic [WIDTH-1:0] in20,
  input  logic [WIDTH-1:0] in21,
  input  logic [WIDTH-1:0] in22,
  input  logic [WIDTH-1:0] in23,
  input  logic [WIDTH-1:0] in24,
  input  logic [WIDTH-1:0] in25,
  input  logic [WIDTH-1:0] in26,
  input  logic [WIDTH-1:0] in27,
  input  logic [WIDTH-1:0] in28,
  input  logic [WIDTH-1:0] in29,
  input  logic [WIDTH-1:0] in30,
  input  logic [WIDTH-1:0] in31,
  input  logic [4:0]       sel,
  input  logic             en,
  output logic [WIDTH-1:0] out
`ifdef REGFILE_READ_MUX32_PARITY_EN
  ,
  output logic             out_par
`endif
);

  localparam logic [WIDTH-1:0] c_ZERO = '0;

  // Candidate words gathered into an array so the index maps 1:1 onto sel.
  logic [WIDTH-1:0] w_in [32];
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;

  assign w_in[0]  = in00;
  assign w_in[1]  = in01;
  assign w_in[2]  = in02;
  assign w_in[3]  = in03;
  assign w_in[4]  = in04;
  assign w_in[5]  = in05;
  assign w_in[6]  = in06;
  assign w_in[7]  = in07;
  assign w_in[8]  = in08;
  assign w_in[9]  = in09;
  assign w_in[10] = in10;
  assign w_in[11] = in11;
  assign w_in[12] = in12;
  assign w_in[13] = in13;
  assign w_in[14] = in14;
  assign w_in[15] = in15;
  assign w_in[16] = in16;
  assign w_in[17] = in17;
  assign w_in[18] = in18;
  assign w_in[19] = in19;
  assign w_in[20] = in20;
  assign w_in[21] = in21;
  assign w_in[22] = in22;
  assign w_in[23] = in23;
  assign w_in[24] = in24;
  assign w_in[25] = in25;
  assign w_in[26] = in26;
  assign w_in[27] = in27;
  assign w_in[28] = in28;
  assign w_in[29] = in29;
  assign w_in[30] = in30;
  assign w_in[31] = in31;

  // Select the addressed word; all 32 codes are legal so no default path.
  always_comb begin
    out_d = w_in[sel];
  end

  // Output register: cleared asynchronously, loaded only when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= c_ZERO;
    end else if (en) begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

`ifdef REGFILE_READ_MUX32_PARITY_EN
  logic par_d;
  logic par_q;

  // Parity is computed from the mux output, not the register, so it lands
  // on the same edge as the word it describes.
  always_comb begin
    par_d = ^out_d;
  end

  // Parity register mirrors the data register's reset and enable behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (en) begin
      par_q <= par_d;
    end
  end

  assign out_par = par_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_read_mux32.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_read_mux32
// Purpose  : Directed self-checking bench for regfile_read_mux32.
//            Parity checks are active when REGFILE_READ_MUX32_PARITY_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_read_mux32;

  logic        clk;
  logic        rst_n;
  logic [31:0] din [32];
  logic [4:0]  sel;
  logic        en;
  logic [31:0] out;
`ifdef REGFILE_READ_MUX32_PARITY_EN
  logic        out_par;
`endif

  int total = 0;
  int bad   = 0;

  regfile_read_mux32 #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in00 (din[0]),  .in01(din[1]),  .in02(din[2]),  .in03(din[3]),
    .in04 (din[4]),  .in05(din[5]),  .in06(din[6]),  .in07(din[7]),
    .in08 (din[8]),  .in09(din[9]),  .in10(din[10]), .in11(din[11]),
    .in12 (din[12]), .in13(din[13]), .in14(din[14]), .in15(din[15]),
    .in16 (din[16]), .in17(din[17]), .in18(din[18]), .in19(din[19]),
    .in20 (din[20]), .in21(din[21]), .in22(din[22]), .in23(din[23]),
    .in24 (din[24]), .in25(din[25]), .in26(din[26]), .in27(din[27]),
    .in28 (din[28]), .in29(din[29]), .in30(din[30]), .in31(din[31]),
    .sel  (sel),
    .en   (en),
    .out  (out)
`ifdef REGFILE_READ_MUX32_PARITY_EN
    ,
    .out_par(out_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    sel   = 5'd7;
    for (int i = 0; i < 32; i++) din[i] = 32'(i);

    // Reset state
    #2;
    chk("reset_init", out, 32'h0);
`ifdef REGFILE_READ_MUX32_PARITY_EN
    chk("reset_init_par", {31'h0, out_par}, 32'h0);
`endif
    tick();
    chk("reset_held_edge", out, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("first_load", out, 32'd7);

    // Asynchronous reset mid-cycle, no clock edge needed
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", out, 32'h0);
    tick();
    chk("reset_ignores_en", out, 32'h0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("after_reset", out, 32'd7);

    // Full sweep of all select codes
    for (int s = 0; s < 32; s++) begin
      sel = 5'(s);
      tick();
      chk($sformatf("sweep_%0d", s), out, 32'(s));
    end

    // Hold behaviour
    sel = 5'd3;
    tick();
    chk("hold_pre", out, 32'd3);
    en  = 1'b0;
    sel = 5'd20;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("hold_%0d", k), out, 32'd3);
    end
    en = 1'b1;
    tick();
    chk("hold_release", out, 32'd20);

    // Simultaneous change of sel and selected input
    sel     = 5'd9;
    din[9]  = 32'h1234_5678;
    tick();
    chk("sel_and_data", out, 32'h1234_5678);

    // Data isolation
    sel     = 5'd31;
    din[31] = 32'hDEAD_BEEF;
    tick();
    chk("iso_start", out, 32'hDEAD_BEEF);
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 31; i++) din[i] = $urandom;
      tick();
      chk($sformatf("iso_%0d", k), out, 32'hDEAD_BEEF);
    end

    // Boundaries
    din[0] = 32'hFFFF_FFFF;
    sel    = 5'd0;
    tick();
    chk("bound_sel0", out, 32'hFFFF_FFFF);
    din[31] = 32'h8000_0001;
    sel     = 5'd31;
    tick();
    chk("bound_sel31", out, 32'h8000_0001);

`ifdef REGFILE_READ_MUX32_PARITY_EN
    chk("par_bound31", {31'h0, out_par}, 32'h0);
    din[5] = 32'h0000_0007;
    sel    = 5'd5;
    tick();
    chk("par_in05_word", out, 32'h7);
    chk("par_in05", {31'h0, out_par}, 32'h1);
    din[6] = 32'h0000_0003;
    sel    = 5'd6;
    tick();
    chk("par_in06", {31'h0, out_par}, 32'h0);
    sel = 5'd5;
    tick();
    chk("par_back05", {31'h0, out_par}, 32'h1);
    en  = 1'b0;
    sel = 5'd6;
    tick();
    chk("par_hold", {31'h0, out_par}, 32'h1);
    en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("par_reset", {31'h0, out_par}, 32'h0);
    rst_n = 1'b1;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
